// File: rtl/alu_regfile_unit_if.sv
// Command/result bundle between the instruction sequencer and alu_regfile_unit.
// master: sequencer side (drives cmd_*, in). slave: unit side (drives cmd_ready, out, flags, busy).
interface alu_regfile_unit_if #(
    parameter int BIT_WIDTH = 8,
    parameter int REG_COUNT = 4
);
    localparam int AW = $clog2(REG_COUNT);

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [3:0]           cmd_op;
    logic [AW-1:0]        cmd_dst;
    logic [AW-1:0]        cmd_src_a;
    logic [AW-1:0]        cmd_src_b;
    logic [BIT_WIDTH-1:0] in;
    logic [BIT_WIDTH-1:0] out;
    logic                 out_valid;
    logic                 cout;
    logic                 zero;
    logic                 busy;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, in,
        input  cmd_ready, out, out_valid, cout, zero, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, in,
        output cmd_ready, out, out_valid, cout, zero, busy
    );
endinterface

// File: rtl/alu_regfile_unit.sv
// Register file + ALU + output register with carry/zero flags behind a ready/valid command port.
// Ports: clk, rst (async active-high), bus (alu_regfile_unit_if.slave). Optional macro ALU_REGFILE_UNIT_MUL_EN adds the iterative multiplier.
module alu_regfile_unit #(
    parameter int BIT_WIDTH = 8,
    parameter int REG_COUNT = 4
) (
    input logic               clk,
    input logic               rst,
    alu_regfile_unit_if.slave bus
);
    localparam int AW = $clog2(REG_COUNT);

    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_MOV  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_OUT  = 4'd8;
`ifdef ALU_REGFILE_UNIT_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd9;
`endif

    logic [BIT_WIDTH-1:0] regs [REG_COUNT];
    logic [BIT_WIDTH-1:0] out_q;
    logic                 out_valid_q;
    logic                 cout_q;
    logic                 zero_q;

    logic                 idle;
    logic                 accept;
    logic                 mul_done;
    logic [BIT_WIDTH-1:0] mul_res;
    logic                 mul_hi;

    logic [BIT_WIDTH-1:0] opa;
    logic [BIT_WIDTH-1:0] opb;
    logic [BIT_WIDTH:0]   sum;
    logic [BIT_WIDTH:0]   diff;
    logic [BIT_WIDTH-1:0] res;
    logic                 res_c;
    logic                 wr_reg;
    logic                 wr_flag;

    assign opa    = regs[bus.cmd_src_a];
    assign opb    = regs[bus.cmd_src_b];
    assign accept = bus.cmd_valid & idle;

    assign sum  = {1'b0, opa} + {1'b0, opb};
    // a + ~b + 1: carry out set means no borrow
    assign diff = {1'b0, opa} + {1'b0, ~opb} + {{BIT_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        res     = '0;
        res_c   = 1'b0;
        wr_reg  = 1'b0;
        wr_flag = 1'b0;
        unique case (bus.cmd_op)
            OP_LOAD: begin res = bus.in; wr_reg = 1'b1; end
            OP_MOV:  begin res = opa; wr_reg = 1'b1; end
            OP_ADD:  begin {res_c, res} = sum; wr_reg = 1'b1; wr_flag = 1'b1; end
            OP_SUB:  begin {res_c, res} = diff; wr_reg = 1'b1; wr_flag = 1'b1; end
            OP_AND:  begin res = opa & opb; wr_reg = 1'b1; wr_flag = 1'b1; end
            OP_OR:   begin res = opa | opb; wr_reg = 1'b1; wr_flag = 1'b1; end
            OP_XOR:  begin res = opa ^ opb; wr_reg = 1'b1; wr_flag = 1'b1; end
            default: ;
        endcase
    end

`ifdef ALU_REGFILE_UNIT_MUL_EN
    localparam int CW = $clog2(BIT_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_WIDTH - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]          cnt_q;
    logic [2*BIT_WIDTH-1:0] mcand_q;
    logic [2*BIT_WIDTH-1:0] acc_q;
    logic [2*BIT_WIDTH-1:0] acc_step;
    logic [BIT_WIDTH-1:0]   mplier_q;
    logic [AW-1:0]          mdst_q;
    logic                   busy_c;

    // Partial product including the current multiplier bit; on the last
    // iteration this is the full product and is written straight back.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_done = (state_q == S_MUL) && (cnt_q == CNT_LAST);
    assign mul_res  = acc_step[BIT_WIDTH-1:0];
    assign mul_hi   = |acc_step[2*BIT_WIDTH-1:BIT_WIDTH];
    assign idle     = (state_q == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        unique case (state_q)
            S_IDLE: if (accept && bus.cmd_op == OP_MUL) state_d = S_MUL;
            S_MUL: begin
                busy_c = 1'b1;
                if (mul_done) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            mdst_q   <= '0;
        end else if (accept && bus.cmd_op == OP_MUL) begin
            cnt_q    <= '0;
            mcand_q  <= {{BIT_WIDTH{1'b0}}, opa};
            acc_q    <= '0;
            mplier_q <= opb;
            mdst_q   <= bus.cmd_dst;
        end else if (state_q == S_MUL) begin
            cnt_q    <= cnt_q + 1'b1;
            mcand_q  <= mcand_q << 1;
            acc_q    <= acc_step;
            mplier_q <= mplier_q >> 1;
        end
    end

    assign bus.busy      = busy_c;
    assign bus.cmd_ready = idle;
`else
    assign idle          = 1'b1;
    assign mul_done      = 1'b0;
    assign mul_res       = '0;
    assign mul_hi        = 1'b0;
    assign bus.busy      = 1'b0;
    assign bus.cmd_ready = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept) begin
                if (wr_reg) regs[bus.cmd_dst] <= res;
                if (wr_flag) begin
                    cout_q <= res_c;
                    zero_q <= (res == '0);
                end
                if (bus.cmd_op == OP_OUT) begin
                    out_q       <= opa;
                    out_valid_q <= 1'b1;
                end
            end
`ifdef ALU_REGFILE_UNIT_MUL_EN
            if (mul_done) begin
                regs[mdst_q] <= mul_res;
                cout_q       <= mul_hi;
                zero_q       <= (mul_res == '0);
            end
`endif
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
endmodule

// File: doc/alu_regfile_unit.md
# alu_regfile_unit

Parametrised datapath unit: a `REG_COUNT`-entry register file, a multi-operation ALU, an output register and carry/zero flags, driven by a ready/valid command interface. It is the next-generation replacement for the fixed two-register ALU datapath and sits between the instruction sequencer and the output port. Single-cycle ops complete at the accepting edge. An optional iterative multiplier holds the interface busy for `BIT_WIDTH` cycles.

## Interface
- `BIT_WIDTH`, default 8: datapath width, ≥2.
- `REG_COUNT`, default 4: register-file depth, power of two, ≥2.
- Derived, not overridable: `AW = $clog2(REG_COUNT)`.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  unit can accept a command.
- `cmd_op`  in  4  opcode.
- `cmd_dst`  in  AW  destination register.
- `cmd_src_a`  in  AW  operand A register.
- `cmd_src_b`  in  AW  operand B register.
- `in`  in  BIT_WIDTH  external load data.
- `out`  out  BIT_WIDTH  output register.
- `out_valid`  out  1  one-cycle pulse when `out` is updated.
- `cout`  out  1  carry flag.
- `zero`  out  1  zero flag.
- `busy`  out  1  multiplier in progress.

## Operation
- Accept condition: `cmd_valid & cmd_ready` at a rising edge. Commands are sampled only at acceptance.
- Opcodes:
  - 0 NOP.
  - 1 LOAD: `r[dst]=in`.
  - 2 MOV: `r[dst]=r[a]`.
  - 3 ADD: `r[dst]=r[a]+r[b]`.
  - 4 SUB: `r[dst]=r[a]-r[b]`.
  - 5 AND, 6 OR, 7 XOR.
  - 8 OUT: `out=r[a]`, `out_valid`=1 for one cycle.
  - 9 MUL: `r[dst]` = low `BIT_WIDTH` bits of `r[a]*r[b]`.
  - 10–15: NOP, still accepted.
- Arithmetic: modulo 2^`BIT_WIDTH`.
- ADD: `cout` = carry out.
- SUB: computed as `a+~b+1`; `cout` = 1 when there is no borrow (a≥b).
- MUL: `cout` = 1 when the upper half of the product is nonzero.
- Logic ops clear `cout`.
- `zero` = (result==0). Updated by ops 3–7 and 9; LOAD, MOV, OUT and NOP leave both flags unchanged.
- FSM has two states:
  - IDLE: `cmd_ready`=1, `busy`=0.
  - MUL: `cmd_ready`=0, `busy`=1.
  - Transitions: IDLE→MUL on accepting op 9. MUL→IDLE after `BIT_WIDTH` iterations.
- Multiplier: shift-add, one multiplier bit per cycle. Operands and `dst` are latched at acceptance, so `dst` may equal a source.
- Reset state:
  - All registers 0; `out`=0, `out_valid`=0, `cout`=0, `zero`=0.
  - FSM in IDLE, so `cmd_ready`=1 during reset. Commands presented while `rst`=1 are ignored.

## Timing
- Single-cycle ops: a command accepted at edge k updates `r[dst]`, flags and `out` at edge k. New values are visible from edge k onward.
- Back-to-back commands are supported. A command accepted at k+1 reads values written at k; no bypass hazard exists.
- `out_valid` is high in exactly the cycle following the OUT accept edge.
- MUL accepted at edge k:
  - `cmd_ready` low from edge k to edge k+`BIT_WIDTH`.
  - Result and flags are written at edge k+`BIT_WIDTH`.
  - `cmd_ready` is high again after edge k+`BIT_WIDTH`; a new command can be accepted at edge k+`BIT_WIDTH`+1.
- `rst` asserted mid-MUL: aborts immediately, no register write, all outputs return to reset values asynchronously.
- `cmd_valid` while `cmd_ready`=0: ignored. The sequencer must hold the command until accepted.

## Configuration
- Macro: `ALU_REGFILE_UNIT_MUL_EN`.
- Defined: op 9 performs the iterative multiply as above, and the MUL state exists.
- Undefined: no multiplier or MUL state is synthesised. Op 9 is a NOP, `busy` is constant 0, and `cmd_ready` is constant 1.

## Test plan
Defaults: `BIT_WIDTH`=8, `REG_COUNT`=4.
- Reset, no commands: `out`=0, `out_valid`=0, `cout`=0, `zero`=0, `cmd_ready`=1.
- LOAD r0=200, LOAD r1=100, ADD r2=r0+r1, OUT r2: `out`=44, `cout`=1, `zero`=0, `out_valid` pulses exactly one cycle.
- SUB r3=r1-r1 → r3=0, `zero`=1, `cout`=1. Then SUB r3=r1-r0 → 156, `zero`=0, `cout`=0. Then AND r3=r0&r1 → 64, `cout`=0.
- Back-to-back: LOAD r1=5 at edge k, ADD r2=r1+r1 at k+1, OUT r2 → `out`=10.
- MUL (macro defined): r0=15, r1=17, MUL r0=r0*r1 → 255, `cout`=0, `cmd_ready` low exactly 8 cycles. Then r0=16, r1=16, MUL → 0, `cout`=1, `zero`=1.
- Assert `rst` 3 cycles into a MUL: destination unchanged (0 after reset), `busy`=0, `cmd_ready`=1. Without the macro, op 9 leaves all registers and flags unchanged.
